// File: rtl/mux_grant_scheduler_if.sv
// Request/grant bundle between the bit-select datapath sources and the mux grant scheduler.
interface mux_grant_scheduler_if #(
  parameter int unsigned NREQ     = 5,
  parameter int unsigned HOLD_MAX = 4
);
  localparam int unsigned CW = $clog2(HOLD_MAX + 1);

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] data_in;
  logic            ovr_req;
  logic            ovr_data;
  logic            cfg_rr;
  logic [NREQ-1:0] gnt;
  logic            gnt_ovr;
  logic            z;
  logic            z_valid;
  logic [CW-1:0]   hold_cnt;

  modport master (
    output req, data_in, ovr_req, ovr_data, cfg_rr,
    input  gnt, gnt_ovr, z, z_valid, hold_cnt
  );

  modport slave (
    input  req, data_in, ovr_req, ovr_data, cfg_rr,
    output gnt, gnt_ovr, z, z_valid, hold_cnt
  );
endinterface

// File: rtl/mux_grant_scheduler.sv
// Arbitrates NREQ requesters plus an override channel onto one registered bit,
// with bounded bursts, a turnaround gap and fixed-priority or round-robin selection.
module mux_grant_scheduler #(
  parameter int unsigned NREQ      = 5,
  parameter int unsigned HOLD_MAX  = 4,
  parameter int unsigned OVR_LEVEL = 3
) (
  input logic                  clk,
  input logic                  rst,
  mux_grant_scheduler_if.slave bus
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t          state;
  logic [NREQ-1:0] gnt_r;
  logic            gnt_ovr_r;
  logic            z_r;
  logic            z_valid_r;
  logic [CW-1:0]   hold_r;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   cur_idx;
  logic            cur_ovr;

  logic            found;
  logic            win_ovr;
  logic            win_any;
  logic [PW-1:0]   win_idx;
  int unsigned     scan_idx;
  logic            src_req;
  logic            src_data;

  // Fixed mode scans from index 0; round-robin scans from rr_ptr with wrap.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    scan_idx = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = bus.cfg_rr ? (32'(rr_ptr) + k) % NREQ : k;
      if (!found && bus.req[PW'(scan_idx)]) begin
        found   = 1'b1;
        win_idx = PW'(scan_idx);
      end
    end
    win_ovr = bus.ovr_req && (bus.req[OVR_LEVEL-1:0] == '0);
    win_any = found || win_ovr;
  end

  assign src_req  = cur_ovr ? bus.ovr_req  : bus.req[cur_idx];
  assign src_data = cur_ovr ? bus.ovr_data : bus.data_in[cur_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt_r     <= '0;
      gnt_ovr_r <= 1'b0;
      z_r       <= 1'b0;
      z_valid_r <= 1'b0;
      hold_r    <= '0;
      rr_ptr    <= '0;
      cur_idx   <= '0;
      cur_ovr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            state   <= GRANT;
            hold_r  <= CW'(1);
            cur_ovr <= win_ovr;
            cur_idx <= win_idx;
            if (win_ovr) gnt_ovr_r <= 1'b1;
            else         gnt_r     <= NREQ'(1) << win_idx;
          end
        end
        GRANT: begin
          if (!src_req || hold_r == CW'(HOLD_MAX)) begin
            state     <= GAP;
            gnt_r     <= '0;
            gnt_ovr_r <= 1'b0;
            z_valid_r <= 1'b0;
            hold_r    <= '0;
            if (!cur_ovr)
              rr_ptr <= (cur_idx == PW'(NREQ - 1)) ? '0 : cur_idx + 1'b1;
          end else begin
            z_r       <= src_data;
            z_valid_r <= 1'b1;
            hold_r    <= hold_r + 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.gnt_ovr  = gnt_ovr_r;
  assign bus.z        = z_r;
  assign bus.z_valid  = z_valid_r;
  assign bus.hold_cnt = hold_r;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0({gnt_ovr_r, gnt_r}));
endmodule

// File: tb/tb_mux_grant_scheduler.sv
// Randomised bench for mux_grant_scheduler: transaction-level reference model feeding
// expected data bits and burst lengths into queues drained by an independent monitor.
module tb_mux_grant_scheduler;
  localparam int NREQ      = 5;
  localparam int HOLD_MAX  = 4;
  localparam int OVR_LEVEL = 3;
  localparam int IW        = $clog2(NREQ);
  localparam int NONE      = -1;
  localparam int OVR       = NREQ;
  localparam logic [NREQ-1:0] LOWMASK = NREQ'((1 << OVR_LEVEL) - 1);

  logic clk = 1'b0;
  logic rst = 1'b0;

  mux_grant_scheduler_if #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) bus ();

  mux_grant_scheduler #(
    .NREQ(NREQ),
    .HOLD_MAX(HOLD_MAX),
    .OVR_LEVEL(OVR_LEVEL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the mux, for how long, and how many quiet cycles remain.
  int   m_owner = NONE;
  int   m_len   = 0;
  int   m_cool  = 0;
  int   m_ptr   = 0;
  logic live;
  logic dbit;
  logic zq[$];
  int   lenq[$];

  int   n_chk = 0;
  int   n_fail = 0;
  int   glen = 0;
  int   timeout_cnt = 0;
  bit   done = 1'b0;

  function automatic int pick(logic [NREQ-1:0] r, logic o, logic rr, int ptr);
    if (o && (r & LOWMASK) == '0) return OVR;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = rr ? (ptr + k) % NREQ : k;
      if (r[IW'(i)]) return i;
    end
    return NONE;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = NONE;
      m_len   = 0;
      m_cool  = 0;
      m_ptr   = 0;
      zq.delete();
      lenq.delete();
    end else if (m_owner == NONE) begin
      if (m_cool > 0) m_cool--;
      else begin
        m_owner = pick(bus.req, bus.ovr_req, bus.cfg_rr, m_ptr);
        if (m_owner != NONE) m_len = 1;
      end
    end else begin
      live = (m_owner == OVR) ? bus.ovr_req  : bus.req[IW'(m_owner)];
      dbit = (m_owner == OVR) ? bus.ovr_data : bus.data_in[IW'(m_owner)];
      if (!live || m_len == HOLD_MAX) begin
        lenq.push_back(m_len);
        if (m_owner != OVR) m_ptr = (m_owner + 1) % NREQ;
        m_owner = NONE;
        m_len   = 0;
        m_cool  = 1;
      end else begin
        zq.push_back(dbit);
        m_len++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int el;
    logic ez;
    if (done) begin
      chk("timeouts", 32'(timeout_cnt), 0);
      chk("z_pending", 32'(zq.size()), 0);
      chk("len_pending", 32'(lenq.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end else if (rst) begin
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_gnt_ovr", 32'(bus.gnt_ovr), 0);
      chk("rst_z", 32'(bus.z), 0);
      chk("rst_z_valid", 32'(bus.z_valid), 0);
      chk("rst_hold_cnt", 32'(bus.hold_cnt), 0);
      glen = 0;
    end else begin
      chk("gnt", 32'(bus.gnt), (m_owner >= 0 && m_owner < NREQ) ? (32'd1 << m_owner) : 32'd0);
      chk("gnt_ovr", 32'(bus.gnt_ovr), 32'(m_owner == OVR));
      chk("onehot", 32'($countones({bus.gnt_ovr, bus.gnt}) <= 1), 1);
      chk("hold_cnt", 32'(bus.hold_cnt), (m_owner == NONE) ? 32'd0 : 32'(m_len));
      chk("z_valid", 32'(bus.z_valid), 32'(zq.size() != 0));
      if (zq.size() != 0) begin
        ez = zq.pop_front();
        if (bus.z_valid) chk("z", 32'(bus.z), 32'(ez));
      end
      if (bus.gnt != '0 || bus.gnt_ovr) glen++;
      else if (glen > 0) begin
        el = (lenq.size() != 0) ? lenq.pop_front() : 0;
        chk("grant_len", 32'(glen), 32'(el));
        glen = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt();
    int t;
    t = 0;
    while (bus.gnt == '0 && !bus.gnt_ovr && t < 20) begin
      cycles(1);
      t++;
    end
    if (t >= 20) timeout_cnt++;
  endtask

  task automatic idle(input int n);
    bus.req     = '0;
    bus.ovr_req = 1'b0;
    cycles(n);
  endtask

  initial begin
    bus.req      = '0;
    bus.data_in  = '0;
    bus.ovr_req  = 1'b0;
    bus.ovr_data = 1'b0;
    bus.cfg_rr   = 1'b0;
    #1 rst = 1'b1;
    cycles(3);
    rst = 1'b0;

    // Fixed priority, steady request set.
    bus.req = 5'b10110;
    bus.data_in = 5'b00010;
    cycles(20);
    idle(4);

    // Round-robin with everyone requesting and data changing every cycle.
    bus.cfg_rr = 1'b1;
    bus.req = '1;
    for (int i = 0; i < 40; i++) begin
      bus.data_in = NREQ'($urandom);
      cycles(1);
    end
    idle(4);
    bus.cfg_rr = 1'b0;

    // Override blocked by a low-index requester, then admitted.
    bus.req = 5'b00100;
    bus.ovr_req = 1'b1;
    cycles(8);
    idle(4);
    bus.req = 5'b10000;
    bus.ovr_req = 1'b1;
    bus.ovr_data = 1'b1;
    cycles(10);
    idle(4);

    // Early release after two grant cycles.
    bus.req = 5'b01000;
    bus.data_in = 5'b01000;
    wait_gnt();
    cycles(1);
    bus.req = '0;
    cycles(6);

    // Asynchronous reset between edges with hold_cnt at 2.
    bus.req = 5'b01000;
    wait_gnt();
    cycles(1);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(8);
    idle(4);

    // Late high-priority request must not preempt.
    bus.req = 5'b01000;
    wait_gnt();
    cycles(1);
    bus.req = 5'b01001;
    bus.data_in = 5'b00001;
    cycles(15);
    idle(4);

    // Random traffic with occasional mode flips and resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int b;
        b = $urandom_range(0, NREQ - 1);
        bus.req[IW'(b)] = ~bus.req[IW'(b)];
      end
      if ($urandom_range(0, 7) == 0) bus.ovr_req = ~bus.ovr_req;
      if ($urandom_range(0, 49) == 0) bus.cfg_rr = ~bus.cfg_rr;
      bus.data_in  = NREQ'($urandom);
      bus.ovr_data = 1'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
      end
      cycles(1);
    end

    idle(12);
    done = 1'b1;
    cycles(5);
    $display("FAIL watchdog: monitor did not close the run");
    $fatal(1);
  end
endmodule
